// File: rtl/regfile_write_arbiter.sv
// Write-port owner for register_file: init sweep, then round-robin arbitration of two requesters.
// Optional: define REGFILE_ARB_R0_DISCARD_EN to drop (but still handshake) RUN writes to register 0.
module regfile_write_arbiter #(
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_start,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [REG_ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]     req0_data,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [REG_ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]     req1_data,
    output logic                      write_en,
    output logic [REG_ADDR_WIDTH-1:0] regw,
    output logic [DATA_WIDTH-1:0]     dataw,
    output logic                      init_busy,
    output logic [CNT_WIDTH-1:0]      conflict_cnt
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                    state;
    logic [REG_ADDR_WIDTH-1:0] sweep_idx;
    logic                      last_grant;  // 0: req0 won last, 1: req1 won last

    logic                      arb_en;
    logic                      grant0;
    logic                      grant1;
    logic                      transfer;
    logic                      both_valid;
    logic [REG_ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0]     win_data;
    logic                      win_we;

    always_comb begin
        init_busy  = (state == StInit);
        // init_start blocks any handshake in the cycle it is seen.
        arb_en     = (state == StRun) && !init_start;
        both_valid = req0_valid && req1_valid;
        grant0     = arb_en && req0_valid && (!req1_valid || last_grant);
        grant1     = arb_en && req1_valid && (!req0_valid || !last_grant);
        req0_ready = grant0;
        req1_ready = grant1;
        transfer   = grant0 || grant1;
        win_addr   = grant1 ? req1_addr : req0_addr;
        win_data   = grant1 ? req1_data : req0_data;
`ifdef REGFILE_ARB_R0_DISCARD_EN
        win_we     = (win_addr != '0);
`else
        win_we     = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StInit;
            sweep_idx    <= '0;
            write_en     <= 1'b0;
            regw         <= '0;
            dataw        <= '0;
            last_grant   <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            unique case (state)
                StInit: begin
                    write_en <= 1'b1;
                    regw     <= sweep_idx;
                    dataw    <= INIT_VALUE;
                    if (sweep_idx == {REG_ADDR_WIDTH{1'b1}}) begin
                        state     <= StRun;
                        sweep_idx <= '0;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
                StRun: begin
                    if (both_valid && (conflict_cnt != {CNT_WIDTH{1'b1}})) begin
                        conflict_cnt <= conflict_cnt + 1'b1;
                    end
                    if (init_start) begin
                        state     <= StInit;
                        sweep_idx <= '0;
                        write_en  <= 1'b0;
                    end else if (transfer) begin
                        last_grant <= grant1;
                        write_en   <= win_we;
                        regw       <= win_addr;
                        dataw      <= win_data;
                    end else begin
                        write_en <= 1'b0;
                    end
                end
                default: state <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register_file model.
module tb_regfile_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_start;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       write_en;
    logic [3:0] regw;
    logic [7:0] dataw;
    logic       init_busy;
    logic [7:0] conflict_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .init_start   (init_start),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .write_en     (write_en),
        .regw         (regw),
        .dataw        (dataw),
        .init_busy    (init_busy),
        .conflict_cnt (conflict_cnt)
    );

    // register_file model: commits on the edge after write_en is registered
    always @(posedge clk) begin
        if (write_en) mem[regw] <= dataw;
    end

    typedef struct {
        logic       v0;
        logic [3:0] a0;
        logic [7:0] d0;
        logic       v1;
        logic [3:0] a1;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
        logic       we;
        logic [3:0] regw;
        logic [7:0] dataw;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        init_start = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        req0_data  = '0;
        req1_data  = '0;
    endtask

    // Checks a full sweep starting from the current (post-edge) point in INIT.
    task automatic check_sweep(input logic hold_req1);
        for (int i = 0; i < 16; i++) begin
            #2;
            chk("sweep_busy", 32'(init_busy), 32'd1);
            chk("sweep_r0", 32'(req0_ready), 32'd0);
            chk("sweep_r1", 32'(req1_ready), 32'd0);
            edge_step();
            chk("sweep_we", 32'(write_en), 32'd1);
            chk("sweep_regw", 32'(regw), 32'(i));
            chk("sweep_dataw", 32'(dataw), 32'd0);
        end
        chk("sweep_done_busy", 32'(init_busy), 32'd0);
        if (hold_req1) begin
            #2;
            chk("first_run_r1", 32'(req1_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        //          v0 a0 d0     v1 a1 d1     r0 r1 we regw dataw  cnt
        vecs[0]  = '{1, 1, 8'h11, 1, 2, 8'h22, 1, 0, 1, 1, 8'h11, 8'd1};
        vecs[1]  = '{1, 1, 8'h11, 1, 2, 8'h22, 0, 1, 1, 2, 8'h22, 8'd2};
        vecs[2]  = '{1, 1, 8'h11, 1, 2, 8'h22, 1, 0, 1, 1, 8'h11, 8'd3};
        vecs[3]  = '{1, 1, 8'h11, 1, 2, 8'h22, 0, 1, 1, 2, 8'h22, 8'd4};
        vecs[4]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 2, 8'h22, 8'd4};
        vecs[5]  = '{1, 3, 8'hA5, 0, 0, 8'h00, 1, 0, 1, 3, 8'hA5, 8'd4};
        vecs[6]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 3, 8'hA5, 8'd4};
        vecs[7]  = '{0, 0, 8'h00, 1, 4, 8'h77, 0, 1, 1, 4, 8'h77, 8'd4};
        vecs[8]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4, 8'h77, 8'd4};
        vecs[9]  = '{1, 6, 8'h66, 1, 7, 8'h88, 1, 0, 1, 6, 8'h66, 8'd5};
        vecs[10] = '{0, 0, 8'h00, 1, 7, 8'h88, 0, 1, 1, 7, 8'h88, 8'd5};
        vecs[11] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 7, 8'h88, 8'd5};

        // Reset state
        rst = 1'b1;
        idle_inputs();
        edge_step();
        edge_step();
        chk("rst_we", 32'(write_en), 32'd0);
        chk("rst_regw", 32'(regw), 32'd0);
        chk("rst_dataw", 32'(dataw), 32'd0);
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_r0", 32'(req0_ready), 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        rst = 1'b0;

        check_sweep(1'b0);
        edge_step();
        chk("post_sweep_we", 32'(write_en), 32'd0);
        for (int i = 0; i < 16; i++) chk("init_mem", 32'(mem[i]), 32'd0);

        // Table-driven RUN arbitration
        for (int k = 0; k < 12; k++) begin
            req0_valid = vecs[k].v0;
            req0_addr  = vecs[k].a0;
            req0_data  = vecs[k].d0;
            req1_valid = vecs[k].v1;
            req1_addr  = vecs[k].a1;
            req1_data  = vecs[k].d1;
            #2;
            chk($sformatf("v%0d_r0", k), 32'(req0_ready), 32'(vecs[k].r0));
            chk($sformatf("v%0d_r1", k), 32'(req1_ready), 32'(vecs[k].r1));
            edge_step();
            chk($sformatf("v%0d_we", k), 32'(write_en), 32'(vecs[k].we));
            chk($sformatf("v%0d_regw", k), 32'(regw), 32'(vecs[k].regw));
            chk($sformatf("v%0d_dataw", k), 32'(dataw), 32'(vecs[k].dataw));
            chk($sformatf("v%0d_cnt", k), 32'(conflict_cnt), 32'(vecs[k].cnt));
        end
        chk("mem1", 32'(mem[1]), 32'h11);
        chk("mem2", 32'(mem[2]), 32'h22);
        chk("mem3", 32'(mem[3]), 32'hA5);
        chk("mem4", 32'(mem[4]), 32'h77);
        chk("mem6", 32'(mem[6]), 32'h66);
        chk("mem7", 32'(mem[7]), 32'h88);

        // init_start in RUN with req1 pending
        init_start = 1'b1;
        req1_valid = 1'b1;
        req1_addr  = 4'd5;
        req1_data  = 8'h5A;
        #2;
        chk("is_r1", 32'(req1_ready), 32'd0);
        chk("is_r0", 32'(req0_ready), 32'd0);
        edge_step();
        init_start = 1'b0;
        chk("is_we", 32'(write_en), 32'd0);
        chk("is_busy", 32'(init_busy), 32'd1);
        check_sweep(1'b1);
        edge_step();
        req1_valid = 1'b0;
        chk("is_acc_we", 32'(write_en), 32'd1);
        chk("is_acc_regw", 32'(regw), 32'd5);
        chk("is_acc_dataw", 32'(dataw), 32'h5A);
        edge_step();
        chk("is_mem5", 32'(mem[5]), 32'h5A);
        chk("is_mem1_cleared", 32'(mem[1]), 32'd0);

        // rst mid-sweep at sweep_idx=7
        init_start = 1'b1;
        edge_step();
        init_start = 1'b0;
        for (int i = 0; i < 7; i++) edge_step();
        chk("mid_regw6", 32'(regw), 32'd6);
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
        chk("mid_rst_we", 32'(write_en), 32'd0);
        chk("mid_rst_busy", 32'(init_busy), 32'd1);
        chk("mid_rst_cnt", 32'(conflict_cnt), 32'd0);
        check_sweep(1'b0);
        edge_step();

        // Write to register 0 in RUN
        req0_valid = 1'b1;
        req0_addr  = 4'd0;
        req0_data  = 8'h55;
        #2;
        chk("r0addr_ready", 32'(req0_ready), 32'd1);
        edge_step();
        req0_valid = 1'b0;
`ifdef REGFILE_ARB_R0_DISCARD_EN
        chk("r0addr_we", 32'(write_en), 32'd0);
        edge_step();
        chk("r0addr_mem0", 32'(mem[0]), 32'd0);
`else
        chk("r0addr_we", 32'(write_en), 32'd1);
        chk("r0addr_dataw", 32'(dataw), 32'h55);
        edge_step();
        chk("r0addr_mem0", 32'(mem[0]), 32'h55);
`endif

        // Conflict counter saturation
        req0_valid = 1'b1;
        req0_addr  = 4'd8;
        req0_data  = 8'h01;
        req1_valid = 1'b1;
        req1_addr  = 4'd9;
        req1_data  = 8'h02;
        for (int i = 0; i < 254; i++) edge_step();
        chk("cnt_254", 32'(conflict_cnt), 32'd254);
        for (int i = 0; i < 6; i++) edge_step();
        chk("cnt_sat", 32'(conflict_cnt), 32'd255);
        idle_inputs();
        edge_step();
        chk("cnt_hold", 32'(conflict_cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
